// File: rtl/ftdi_rx_framer.sv
// FTDI 245 synchronous-FIFO receiver: packs 7-bit payload bytes into pixel words
// for the framebuffer, with frame-start resync, error counting and swap handshake.
module ftdi_rx_framer #(
  parameter int BYTES_PER_PIXEL = 3,
  parameter int ADDR_WIDTH      = 14,
  parameter int FRAME_PIXELS    = 16384,
  localparam int DATA_WIDTH     = 7 * BYTES_PER_PIXEL
) (
  input  logic                  clk_60,
  input  logic                  rst,
  input  logic [7:0]            data_in,
  input  logic                  rxf_n,
  input  logic                  txe_n,
  output logic                  oe_n,
  output logic                  rd_n,
  output logic                  wr_n,
  output logic [DATA_WIDTH-1:0] fb_wdata,
  output logic [ADDR_WIDTH-1:0] fb_waddr,
  output logic                  fb_we,
  output logic                  full,
  input  logic                  swapped,
  output logic [15:0]           frame_count,
  output logic [7:0]            err_count
);

  localparam int PHASE_W = $clog2(BYTES_PER_PIXEL);
  localparam logic [PHASE_W-1:0]    LAST_PHASE = PHASE_W'(BYTES_PER_PIXEL - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIXEL = ADDR_WIDTH'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    OE,
    READ
  } state_t;

  state_t                  state;
  logic                    synced;
  logic [PHASE_W-1:0]      phase;
  logic [ADDR_WIDTH-1:0]   pixel;
  logic [DATA_WIDTH-1:0]   shreg;

  logic                    accept;
  logic                    flag;
  logic                    eff_synced;
  logic [PHASE_W-1:0]      eff_phase;
  logic [ADDR_WIDTH-1:0]   eff_pixel;
  logic                    pixel_done;
  logic                    last;
  logic                    in_progress;
  logic                    misalign;
  logic [DATA_WIDTH-1:0]   word_next;

  // Receive-only block: txe_n is sunk here to keep the FIFO bus complete.
  logic unused_txe;
  assign unused_txe = txe_n;

  assign wr_n = 1'b1;

  // A flagged byte is always byte 0 of pixel 0, regardless of the current counters.
  assign accept      = (state == READ) && !rxf_n;
  assign flag        = data_in[7];
  assign eff_synced  = synced || flag;
  assign eff_phase   = flag ? '0 : phase;
  assign eff_pixel   = flag ? '0 : pixel;
  assign pixel_done  = accept && eff_synced && (eff_phase == LAST_PHASE);
  assign last        = pixel_done && (eff_pixel == LAST_PIXEL);
  assign in_progress = synced && ((phase != '0) || (pixel != '0));
  assign misalign    = accept && flag && in_progress;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    word_next = flag ? '0 : shreg;
    for (int b = 0; b < BYTES_PER_PIXEL; b++) begin
      if (eff_phase == PHASE_W'(b)) begin
        word_next[7*(BYTES_PER_PIXEL-1-b) +: 7] = data_in[6:0];
      end
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_60) begin
    if (rst) begin
      state       <= IDLE;
      oe_n        <= 1'b1;
      rd_n        <= 1'b1;
      fb_we       <= 1'b0;
      fb_waddr    <= '0;
      fb_wdata    <= '0;
      full        <= 1'b0;
      frame_count <= '0;
      err_count   <= '0;
      synced      <= 1'b0;
      phase       <= '0;
      pixel       <= '0;
      shreg       <= '0;
    end else begin
      fb_we <= 1'b0;

      // FIFO handshake; oe_n/rd_n are registered from the state being entered.
      case (state)
        IDLE: begin
          if (!rxf_n && !full) begin
            state <= OE;
            oe_n  <= 1'b0;
            rd_n  <= 1'b1;
          end else begin
            state <= IDLE;
            oe_n  <= 1'b1;
            rd_n  <= 1'b1;
          end
        end
        OE: begin
          if (!rxf_n && !full) begin
            state <= READ;
            oe_n  <= 1'b0;
            rd_n  <= 1'b0;
          end else begin
            state <= IDLE;
            oe_n  <= 1'b1;
            rd_n  <= 1'b1;
          end
        end
        READ: begin
          if (rxf_n || last) begin
            state <= IDLE;
            oe_n  <= 1'b1;
            rd_n  <= 1'b1;
          end else begin
            state <= READ;
            oe_n  <= 1'b0;
            rd_n  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          oe_n  <= 1'b1;
          rd_n  <= 1'b1;
        end
      endcase

      // Framing priority: flag restart, frame completion, swap handling, normal packing.
      if (accept && flag) begin
        if (misalign && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
        synced <= 1'b1;
        phase  <= PHASE_W'(1);
        pixel  <= '0;
        shreg  <= word_next;
      end else if (last) begin
        fb_we       <= 1'b1;
        fb_waddr    <= pixel;
        fb_wdata    <= word_next;
        full        <= 1'b1;
        frame_count <= frame_count + 16'd1;
        synced      <= 1'b0;
        phase       <= '0;
        pixel       <= '0;
        shreg       <= '0;
      end else if (swapped && full) begin
        full   <= 1'b0;
        synced <= 1'b0;
        phase  <= '0;
        pixel  <= '0;
        shreg  <= '0;
      end else if (swapped && in_progress) begin
        if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
        synced <= 1'b0;
        phase  <= '0;
        pixel  <= '0;
        shreg  <= '0;
      end else if (accept && synced) begin
        shreg <= word_next;
        if (pixel_done) begin
          fb_we    <= 1'b1;
          fb_waddr <= pixel;
          fb_wdata <= word_next;
          phase    <= '0;
          pixel    <= pixel + 1'b1;
        end else begin
          phase <= phase + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ftdi_rx_framer.sv
// Self-checking bench for ftdi_rx_framer: FIFO model feeding bytes, scoreboard of
// expected framebuffer writes, plus direct checks of handshake and counters.
module tb_ftdi_rx_framer;

  localparam int BPP = 3;
  localparam int AW  = 14;
  localparam int FP  = 4;
  localparam int DW  = 7 * BPP;

  logic          clk_60;
  logic          rst;
  logic [7:0]    data_in;
  logic          rxf_n;
  logic          txe_n;
  logic          oe_n;
  logic          rd_n;
  logic          wr_n;
  logic [DW-1:0] fb_wdata;
  logic [AW-1:0] fb_waddr;
  logic          fb_we;
  logic          full;
  logic          swapped;
  logic [15:0]   frame_count;
  logic [7:0]    err_count;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    logic [15:0]   fc;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] fifo_q[$];
  bit         hold;
  int         n_checks;
  int         n_errors;
  int         exp_fc;
  int         exp_err;

  ftdi_rx_framer #(
    .BYTES_PER_PIXEL(BPP),
    .ADDR_WIDTH     (AW),
    .FRAME_PIXELS   (FP)
  ) dut (
    .clk_60     (clk_60),
    .rst        (rst),
    .data_in    (data_in),
    .rxf_n      (rxf_n),
    .txe_n      (txe_n),
    .oe_n       (oe_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .fb_wdata   (fb_wdata),
    .fb_waddr   (fb_waddr),
    .fb_we      (fb_we),
    .full       (full),
    .swapped    (swapped),
    .frame_count(frame_count),
    .err_count  (err_count)
  );

  initial begin
    clk_60 = 1'b0;
    forever #5 clk_60 = ~clk_60;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pack(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
    return {a[6:0], b[6:0], c[6:0]};
  endfunction

  // FIFO model: a byte leaves the queue when the DUT had rd_n low while rxf_n was low.
  initial begin
    bit take;
    rxf_n   = 1'b1;
    data_in = 8'h00;
    forever begin
      @(negedge clk_60);
      take = !rd_n && !rxf_n;
      @(posedge clk_60);
      #1;
      if (take && fifo_q.size() > 0) void'(fifo_q.pop_front());
      rxf_n   = hold || (fifo_q.size() == 0);
      data_in = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  // Write monitor: every fb_we must match the head of the expectation queue.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk_60);
      if (fb_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("spurious_we", 32'(fb_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(fb_waddr), 32'(e.addr));
          check("wr_data", 32'(fb_wdata), 32'(e.data));
          check("wr_full", 32'(full), 32'(e.last));
          if (e.last) begin
            check("eof_frame_count", 32'(frame_count), 32'(e.fc));
            check("eof_rd_n", 32'(rd_n), 32'd1);
          end
        end
      end
    end
  end

  // Queue n bytes of a frame built from seed; byte 0 is flagged. Expect writes for complete pixels.
  task automatic send_bytes(input logic [6:0] seed, input int n, input bit first_queued);
    logic [7:0] b[12];
    for (int i = 0; i < 12; i++) begin
      b[i] = {(i == 0) ? 1'b1 : 1'b0, 7'(int'(seed) + i * 5)};
    end
    for (int j = 0; j < n / BPP; j++) begin
      if (j == FP - 1) exp_fc++;
      exp_q.push_back('{addr: AW'(j), data: pack(b[3*j], b[3*j+1], b[3*j+2]),
                        last: (j == FP - 1), fc: 16'(exp_fc)});
    end
    for (int i = (first_queued ? 1 : 0); i < n; i++) fifo_q.push_back(b[i]);
  endtask

  task automatic drain(input int keep);
    int n = 0;
    while ((fifo_q.size() > keep || exp_q.size() != 0) && n < 400) begin
      @(negedge clk_60);
      n++;
    end
    check("drain_done", 32'(fifo_q.size() <= keep && exp_q.size() == 0), 32'd1);
  endtask

  task automatic pulse_swap();
    @(negedge clk_60);
    swapped = 1'b1;
    @(negedge clk_60);
    swapped = 1'b0;
  endtask

  initial begin
    int wait_n;
    n_checks = 0;
    n_errors = 0;
    exp_fc   = 0;
    exp_err  = 0;
    hold     = 1'b0;
    txe_n    = 1'b1;
    swapped  = 1'b0;
    rst      = 1'b1;

    repeat (3) @(negedge clk_60);
    check("rst_oe_n", 32'(oe_n), 32'd1);
    check("rst_rd_n", 32'(rd_n), 32'd1);
    check("rst_wr_n", 32'(wr_n), 32'd1);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_waddr", 32'(fb_waddr), 32'd0);
    check("rst_wdata", 32'(fb_wdata), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;

    // First pixel: handshake sequence and one-cycle write latency.
    @(negedge clk_60);
    fifo_q.push_back(8'h81);
    fifo_q.push_back(8'h02);
    fifo_q.push_back(8'h03);
    exp_q.push_back('{addr: '0, data: 21'h004103, last: 1'b0, fc: 16'd0});
    @(negedge clk_60);
    check("seq_idle_oe_n", 32'(oe_n), 32'd1);
    check("seq_idle_rd_n", 32'(rd_n), 32'd1);
    @(negedge clk_60);
    check("seq_oe_oe_n", 32'(oe_n), 32'd0);
    check("seq_oe_rd_n", 32'(rd_n), 32'd1);
    @(negedge clk_60);
    check("seq_read_oe_n", 32'(oe_n), 32'd0);
    check("seq_read_rd_n", 32'(rd_n), 32'd0);
    @(negedge clk_60);
    check("lat_we_b1", 32'(fb_we), 32'd0);
    @(negedge clk_60);
    check("lat_we_b2", 32'(fb_we), 32'd0);
    @(negedge clk_60);
    check("lat_we_b3", 32'(fb_we), 32'd1);

    // Reset in the middle of pixel 1: no write may follow for the partial pixel.
    @(negedge clk_60);
    fifo_q.push_back(8'h04);
    fifo_q.push_back(8'h05);
    drain(0);
    rst = 1'b1;
    @(negedge clk_60);
    check("midrst_oe_n", 32'(oe_n), 32'd1);
    check("midrst_wdata", 32'(fb_wdata), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk_60);

    // Full frame, with the next frame's flag byte waiting behind it.
    send_bytes(7'h10, 12, 1'b0);
    fifo_q.push_back(8'h81);
    drain(1);
    repeat (4) begin
      @(negedge clk_60);
      check("full_stall", 32'(rd_n && oe_n), 32'd1);
    end
    check("byte13_kept", 32'(fifo_q.size()), 32'd1);
    check("full_set", 32'(full), 32'd1);
    check("frame_count_1", 32'(frame_count), 32'd1);

    // Swap clears full; the queued flag byte starts the next frame at address 0.
    send_bytes(7'h01, 12, 1'b1);
    pulse_swap();
    check("swap_clears_full", 32'(full), 32'd0);
    drain(0);
    check("frame_count_2", 32'(frame_count), 32'd2);
    pulse_swap();

    // Short frame: 5 bytes then a new flag.
    send_bytes(7'h20, 5, 1'b0);
    exp_err++;
    send_bytes(7'h33, 12, 1'b0);
    drain(0);
    check("short_frame_err", 32'(err_count), 32'(exp_err));
    pulse_swap();

    // Unsynced bytes before the first flag are discarded.
    fifo_q.push_back(8'h05);
    fifo_q.push_back(8'h06);
    send_bytes(7'h44, 12, 1'b0);
    drain(0);
    check("unsynced_err", 32'(err_count), 32'(exp_err));
    pulse_swap();

    // rxf_n held high mid-pixel: nothing moves, then the frame completes.
    send_bytes(7'h55, 12, 1'b0);
    wait_n = 0;
    while (fifo_q.size() > 8 && wait_n < 100) begin
      @(negedge clk_60);
      wait_n++;
    end
    hold = 1'b1;
    repeat (4) @(negedge clk_60);
    check("hold_no_accept", 32'(fifo_q.size()), 32'd7);
    check("hold_no_write", 32'(exp_q.size()), 32'd3);
    hold = 1'b0;
    drain(0);
    pulse_swap();

    // Swap mid-frame aborts with an error; a swap while idle does nothing.
    send_bytes(7'h66, 5, 1'b0);
    drain(0);
    pulse_swap();
    exp_err++;
    check("abort_err", 32'(err_count), 32'(exp_err));
    pulse_swap();
    check("idle_swap_err", 32'(err_count), 32'(exp_err));

    // Back-to-back flags: every flag after the first is misaligned.
    for (int i = 0; i < 260; i++) fifo_q.push_back(8'h80 | 8'(i & 8'h7F));
    exp_err = (exp_err + 259 > 255) ? 255 : exp_err + 259;
    drain(0);
    @(negedge clk_60);
    check("err_saturate", 32'(err_count), 32'(exp_err));
    check("frame_count_end", 32'(frame_count), 32'(exp_fc));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
